// File: rtl/mul_div_unit_pkg.sv
// mul_div_pkg: op codes and FSM state encoding shared by the multiply/divide unit
package mul_div_pkg;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_op(input logic [3:0] c);
    return c == OP_MULT || c == OP_MULTU || c == OP_DIV || c == OP_DIVU;
  endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the datapath and the multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 16);
  logic               start;
  logic [3:0]         control;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] r;
  logic               busy;
  logic               validity;
  logic               div_by_zero;
  modport master(output start, control, a, b, input r, busy, validity, div_by_zero);
  modport slave(input start, control, a, b, output r, busy, validity, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply and divide, one step per clock, result {HI, LO}
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_div, r_neg_q, r_neg_r, r_dbz;
  logic [WIDTH-1:0]   r_opb, r_a_raw;
  logic [2*WIDTH-1:0] r_acc, r_r;
  logic               r_busy, r_valid, r_dbz_out;
  logic               w_accept, w_signed, w_a_neg, w_b_neg, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_diff, w_q, w_rem;
  logic [WIDTH:0]     w_sum, w_top;
  logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_res;
  assign w_accept = r_state == IDLE && bus.start && is_op(bus.control);
  assign w_signed = ~bus.control[0];
  assign w_a_neg  = w_signed & bus.a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b  = w_b_neg ? -bus.b : bus.b;
  // multiply step: add multiplicand into HI when the LSB is set, then shift the whole accumulator right
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
  assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
  // divide step: shift left, trial-subtract divisor from the partial remainder, keep it only if non-negative
  assign w_top      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_top >= {1'b0, r_opb};
  assign w_diff     = w_top[WIDTH-1:0] - r_opb;
  assign w_div_step = {w_ge ? w_diff : w_top[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_q        = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_res      = r_dbz ? {r_a_raw, {WIDTH{1'b1}}} : r_div ? {w_rem, w_q} : r_neg_q ? -r_acc : r_acc;
  assign bus.r           = r_r;
  assign bus.busy        = r_busy;
  assign bus.validity    = r_valid;
  assign bus.div_by_zero = r_dbz_out;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state: RUN lasts until the iteration counter is exhausted, DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? RUN : IDLE) : r_state == RUN ? (r_cnt == CW'(1) ? DONE : RUN) : IDLE;
  end
  // datapath: latch magnitudes and signs on accept, iterate in RUN, sign-correct and publish in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r       <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_dbz_out <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_a_raw   <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_div     <= bus.control[1];
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_dbz     <= bus.control[1] && bus.b == '0;
        r_opb     <= bus.control[1] ? w_abs_b : w_abs_a;
        r_acc     <= {{WIDTH{1'b0}}, bus.control[1] ? w_abs_a : w_abs_b};
        r_a_raw   <= bus.a;
        r_cnt     <= CW'(WIDTH);
        r_busy    <= 1'b1;
        r_dbz_out <= 1'b0;
      end else if (r_state == RUN) begin
        r_acc <= r_div ? w_div_step : w_mul_step;
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == DONE) begin
        r_r       <= w_res;
        r_valid   <= 1'b1;
        r_busy    <= 1'b0;
        r_dbz_out <= r_dbz;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus handshake/reset sequences for mul_div_unit
module tb_mul_div_unit;
  import mul_div_pkg::*;
  localparam int W = 16;
  typedef struct packed {
    logic [3:0]     ctl;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;
    logic           dz;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t v [13];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic wait_valid(input string name, input int t0, input int lat);
    int n = 0;
    while (bus.validity !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 64'(cyc - t0), 64'(lat));
  endtask
  task automatic run_op(input int idx, input vec_t t);
    string nm;
    int t0;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.start = 1'b1; bus.control = t.ctl; bus.a = t.a; bus.b = t.b;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    check({nm, " busy_on_start"}, 64'(bus.busy), 64'd1);
    check({nm, " dbz_cleared"}, 64'(bus.div_by_zero), 64'd0);
    wait_valid(nm, t0, W + 1);
    check({nm, " r"}, 64'(bus.r), 64'(t.r));
    check({nm, " dbz"}, 64'(bus.div_by_zero), 64'(t.dz));
    @(posedge clk); #1;
    check({nm, " valid_one_cycle"}, 64'({bus.validity, bus.busy}), 64'd0);
    check({nm, " r_held"}, 64'(bus.r), 64'(t.r));
    check({nm, " dbz_held"}, 64'(bus.div_by_zero), 64'(t.dz));
  endtask
  initial begin
    int t0;
    int pulses;
    logic [2*W-1:0] r_prev;
    v[0]  = '{OP_MULT,  16'd21845, 16'd1,     32'h0000_5555, 1'b0};
    v[1]  = '{OP_MULT,  16'd1,     16'd21845, 32'h0000_5555, 1'b0};
    v[2]  = '{OP_MULT,  16'hFFFF,  16'd21845, 32'hFFFF_AAAB, 1'b0};
    v[3]  = '{OP_MULTU, 16'hFFFF,  16'd21845, 32'h5554_AAAB, 1'b0};
    v[4]  = '{OP_DIV,   16'hFFF9,  16'd2,     32'hFFFF_FFFD, 1'b0};
    v[5]  = '{OP_DIVU,  16'd10922, 16'd2,     32'h0000_1555, 1'b0};
    v[6]  = '{OP_DIVU,  16'd21845, 16'd0,     32'h5555_FFFF, 1'b1};
    v[7]  = '{OP_DIV,   16'h8000,  16'hFFFF,  32'h0000_8000, 1'b0};
    v[8]  = '{OP_MULT,  16'h8000,  16'h8000,  32'h4000_0000, 1'b0};
    v[9]  = '{OP_MULTU, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001, 1'b0};
    v[10] = '{OP_DIV,   16'd7,     16'hFFFE,  32'h0001_FFFD, 1'b0};
    v[11] = '{OP_DIV,   16'hFFF9,  16'hFFFE,  32'hFFFF_0003, 1'b0};
    v[12] = '{OP_DIV,   16'hFFF9,  16'd0,     32'hFFF9_FFFF, 1'b1};
    bus.start = 1'b0; bus.control = 4'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({bus.r, bus.busy, bus.validity, bus.div_by_zero}), 64'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 13; i++) run_op(i, v[i]);
    @(negedge clk);
    bus.start = 1'b1; bus.control = OP_MULT; bus.a = 16'd21845; bus.b = 16'd1;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.control = OP_MULTU; bus.a = 16'd2; bus.b = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_while_busy busy", 64'(bus.busy), 64'd1);
    wait_valid("start_while_busy", t0, W + 1);
    check("start_while_busy r", 64'(bus.r), 64'h0000_5555);
    @(posedge clk); #1;
    check("start_while_busy no_second_op", 64'(bus.busy), 64'd0);
    r_prev = bus.r;
    @(negedge clk);
    bus.start = 1'b1; bus.control = 4'b0011; bus.a = 16'd9; bus.b = 16'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("invalid_op busy", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("invalid_op r_unchanged", 64'({bus.r, bus.busy, bus.validity}), 64'({r_prev, 2'b00}));
    @(negedge clk);
    bus.start = 1'b1; bus.control = OP_DIV; bus.a = 16'd100; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort r", 64'(bus.r), 64'd0);
    check("abort validity", 64'(bus.validity), 64'd0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.validity === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    check("abort no_pulse", 64'(pulses), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
